// File: rtl/sd_pkg.sv
// Constants and state encoding for the SD card clock controller.
// The command and data FSMs import this package as well.
package sd_pkg;

  localparam int SD_DIV_BITS    = 8;
  localparam int SD_DEF_DIV     = 62;
  localparam int SD_INIT_CYCLES = 80;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUN     = 2'd1,
    INIT    = 2'd2
  } sd_state_e;

endpackage

// File: rtl/sd_clk_div.sv
// Half-period counter and sd_clk toggle register. It also produces the edge
// strobes and flags the period boundary, i.e. the cycle before a 0->1 toggle.
module sd_clk_div
  import sd_pkg::*;
#(
  parameter int DIV_BITS = SD_DIV_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                park,
  input  logic [DIV_BITS-1:0] div,
  output logic                sd_clk,
  output logic                sd_clk_rise,
  output logic                sd_clk_fall,
  output logic                bnd,
  output logic                fall_now
);

  logic [DIV_BITS-1:0] cnt;
  logic                tc;

  assign tc       = run && (cnt == div);
  assign bnd      = tc && !sd_clk;
  assign fall_now = tc && sd_clk;

  // park is only raised on a boundary, where sd_clk is already low, so
  // clearing here never cuts a high phase short.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      sd_clk      <= 1'b0;
      sd_clk_rise <= 1'b0;
      sd_clk_fall <= 1'b0;
    end else begin
      sd_clk_rise <= 1'b0;
      sd_clk_fall <= 1'b0;
      if (!run || park) begin
        cnt    <= '0;
        sd_clk <= 1'b0;
      end else if (tc) begin
        cnt         <= '0;
        sd_clk      <= ~sd_clk;
        sd_clk_rise <= ~sd_clk;
        sd_clk_fall <= sd_clk;
      end else begin
        cnt <= cnt + DIV_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/sd_clk_ctrl.sv
// SD card clock controller: run/stop/init-burst sequencing and glitch-free
// divisor changes. All transitions and divisor swaps land on a period boundary.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   STOPPED | sd_clk parked low, counter cleared
//   RUN     | free-running divider, follows clk_en
//   INIT    | init burst of INIT_CYCLES periods, independent of clk_en
module sd_clk_ctrl
  import sd_pkg::*;
#(
  parameter int DIV_BITS    = SD_DIV_BITS,
  parameter int DEF_DIV     = SD_DEF_DIV,
  parameter int INIT_CYCLES = SD_INIT_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic [DIV_BITS-1:0] div_in,
  input  logic                div_load,
  output logic                div_ack,
  input  logic                init_start,
  output logic                init_done,
  output logic                sd_clk,
  output logic                sd_clk_rise,
  output logic                sd_clk_fall,
  output logic                busy
);

  localparam int                  ICNT_W    = $clog2(INIT_CYCLES + 1);
  localparam logic [DIV_BITS-1:0] DEF_DIV_V = DIV_BITS'(DEF_DIV);
  localparam logic [ICNT_W-1:0]   INIT_LAST = ICNT_W'(INIT_CYCLES);

  sd_state_e           state, state_nxt;
  logic [DIV_BITS-1:0] div_act;
  logic [DIV_BITS-1:0] div_pend;
  logic                pend_vld;
  logic                init_req;
  logic [ICNT_W-1:0]   init_cnt;

  logic run, park, bnd, fall_now, apply, init_end;

  sd_clk_div #(.DIV_BITS(DIV_BITS)) u_div (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .park       (park),
    .div        (div_act),
    .sd_clk     (sd_clk),
    .sd_clk_rise(sd_clk_rise),
    .sd_clk_fall(sd_clk_fall),
    .bnd        (bnd),
    .fall_now   (fall_now)
  );

  always_comb begin
    state_nxt = state;
    init_end  = 1'b0;
    case (state)
      STOPPED: begin
        if (init_start)  state_nxt = INIT;
        else if (clk_en) state_nxt = RUN;
      end
      RUN: begin
        if (bnd) begin
          if (init_req || init_start) state_nxt = INIT;
          else if (!clk_en)           state_nxt = STOPPED;
        end
      end
      INIT: begin
        if (bnd && (init_cnt == INIT_LAST)) begin
          init_end  = 1'b1;
          state_nxt = clk_en ? RUN : STOPPED;
        end
      end
      default: state_nxt = STOPPED;
    endcase

    // Counting already in the start cycle puts the first rise div+1 cycles
    // after the request instead of div+2.
    run   = (state != STOPPED) || clk_en || init_start;
    park  = bnd && (state_nxt == STOPPED);
    apply = pend_vld && ((state == STOPPED) || bnd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= STOPPED;
      div_act  <= DEF_DIV_V;
      div_pend <= '0;
      pend_vld <= 1'b0;
      init_req <= 1'b0;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;

      // A load in the apply cycle becomes the next pending value.
      if (div_load) begin
        div_pend <= div_in;
        pend_vld <= 1'b1;
      end else if (apply) begin
        pend_vld <= 1'b0;
      end
      if (apply) div_act <= div_pend;

      init_req <= (state == RUN) && (init_req || init_start) && (state_nxt != INIT);

      if ((state != INIT) || init_end) init_cnt <= '0;
      else if (fall_now)               init_cnt <= init_cnt + ICNT_W'(1);
    end
  end

  assign div_ack   = apply;
  assign init_done = init_end;
  assign busy      = (state == INIT) || pend_vld;

endmodule

// File: tb/tb_sd_clk_ctrl.sv
// Directed bench for sd_clk_ctrl; expected edge/ack times are hand-derived
// for DEF_DIV=1 and INIT_CYCLES=80.
module tb_sd_clk_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_en;
  logic [7:0] div_in;
  logic       div_load;
  logic       div_ack;
  logic       init_start;
  logic       init_done;
  logic       sd_clk;
  logic       sd_clk_rise;
  logic       sd_clk_fall;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sd_clk_ctrl #(.DIV_BITS(8), .DEF_DIV(1), .INIT_CYCLES(80)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .div_in     (div_in),
    .div_load   (div_load),
    .div_ack    (div_ack),
    .init_start (init_start),
    .init_done  (init_done),
    .sd_clk     (sd_clk),
    .sd_clk_rise(sd_clk_rise),
    .sd_clk_fall(sd_clk_fall),
    .busy       (busy)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_sdclk"}, sd_clk, 0);
    chk({tag, "_rise"}, sd_clk_rise, 0);
    chk({tag, "_fall"}, sd_clk_fall, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ack"}, div_ack, 0);
    chk({tag, "_done"}, init_done, 0);
  endtask

  int rise_t[$];
  int fall_t[$];
  int ack_t[$];
  int exp_rise[8] = '{4, 12, 14, 16, 18, 26, 32, 38};
  int exp_fall[8] = '{8, 13, 15, 17, 22, 29, 35, 41};
  int exp_ack[3]  = '{11, 17, 25};
  int exp_rr[3]   = '{2, 6, 10};

  initial begin
    int hi_cnt, n_r, n_f, n_d, done_t, n_a;

    rst = 1'b1; clk_en = 1'b0; div_in = 8'd0; div_load = 1'b0; init_start = 1'b0;
    @(negedge clk);
    tick();
    check_idle("rst_hold");
    rst = 1'b0;
    tick();
    check_idle("rst_rel");

    // Run at DEF_DIV=1: period 4, first rise two cycles after enable.
    clk_en = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      chk("t1_sdclk", sd_clk, int'((t >= 2) && (((t - 2) % 4) < 2)));
      chk("t1_rise", sd_clk_rise, int'((t >= 2) && (((t - 2) % 4) == 0)));
      chk("t1_fall", sd_clk_fall, int'((t >= 2) && (((t - 2) % 4) == 2)));
    end
    clk_en = 1'b0;
    n_r = 0; n_f = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      n_r += int'(sd_clk_rise);
      n_f += int'(sd_clk_fall);
    end
    chk("stop_rises", n_r, 0);
    chk("stop_falls", n_f, 1);
    chk("stop_sdclk", sd_clk, 0);

    // Divisor load while stopped is acked one cycle after capture.
    div_load = 1'b1; div_in = 8'd3;
    tick();
    div_load = 1'b0;
    chk("stop_ack", div_ack, 1);
    chk("stop_busy", busy, 1);
    tick();
    chk("stop_ack_clr", div_ack, 0);
    chk("stop_busy_clr", busy, 0);

    // RUN at div=3, change to 0 mid-high, back to 3, then 5 overwritten by 2,
    // then drop clk_en one cycle after a rise.
    clk_en = 1'b1;
    hi_cnt = 0;
    for (int t = 1; t <= 50; t++) begin
      tick();
      if (sd_clk_rise) rise_t.push_back(t);
      if (sd_clk_fall) fall_t.push_back(t);
      if (div_ack) ack_t.push_back(t);
      if (t >= 38 && sd_clk) hi_cnt++;
      if (t == 6)  chk("busy_pend0", busy, 1);
      if (t == 12) chk("busy_clr0", busy, 0);
      if (t == 21) chk("busy_pend5", busy, 1);
      if (t == 26) chk("busy_clr2", busy, 0);
      div_load = 1'b0;
      case (t)
        5:  begin div_load = 1'b1; div_in = 8'd0; end
        16: begin div_load = 1'b1; div_in = 8'd3; end
        19: begin div_load = 1'b1; div_in = 8'd5; end
        21: begin div_load = 1'b1; div_in = 8'd2; end
        38: clk_en = 1'b0;
        default: ;
      endcase
    end
    chk("run_nrise", rise_t.size(), 8);
    chk("run_nfall", fall_t.size(), 8);
    chk("run_nack", ack_t.size(), 3);
    for (int i = 0; i < 8; i++) begin
      chk("run_rise_t", (i < rise_t.size()) ? rise_t[i] : -1, exp_rise[i]);
      chk("run_fall_t", (i < fall_t.size()) ? fall_t[i] : -1, exp_fall[i]);
    end
    for (int i = 0; i < 3; i++)
      chk("run_ack_t", (i < ack_t.size()) ? ack_t[i] : -1, exp_ack[i]);
    chk("drop_high_len", hi_cnt, 3);
    chk("drop_sdclk", sd_clk, 0);

    // Back in STOPPED: immediate ack proves the stop; div=0 for the burst.
    div_load = 1'b1; div_in = 8'd0;
    tick();
    div_load = 1'b0;
    chk("stop2_ack", div_ack, 1);
    tick();
    chk("stop2_busy_clr", busy, 0);

    // Init burst with clk_en=0.
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    chk("init_busy", busy, 1);
    chk("init_first_rise", sd_clk_rise, 1);
    n_f = 0; n_d = 0; done_t = -1; n_r = 0;
    for (int t = 2; t <= 200; t++) begin
      tick();
      n_f += int'(sd_clk_fall);
      if (init_done) begin n_d++; done_t = t; end
      if (t > 160 && sd_clk_rise) n_r++;
    end
    chk("init_falls", n_f, 80);
    chk("init_done_cnt", n_d, 1);
    chk("init_done_t", done_t, 160);
    chk("init_rises_after", n_r, 0);
    chk("init_end_sdclk", sd_clk, 0);
    chk("init_end_busy", busy, 0);

    // Reset in the middle of a burst with a divisor pending.
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    for (int t = 2; t <= 8; t++) tick();
    div_load = 1'b1; div_in = 8'd4;
    tick();
    div_load = 1'b0;
    chk("mid_busy", busy, 1);
    chk("mid_ack", div_ack, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("mid_rst");
    n_a = 0; n_d = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      n_a += int'(div_ack);
      n_d += int'(init_done);
    end
    chk("post_rst_acks", n_a, 0);
    chk("post_rst_done", n_d, 0);
    chk("post_rst_sdclk", sd_clk, 0);

    rise_t.delete();
    clk_en = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (sd_clk_rise) rise_t.push_back(t);
    end
    chk("rerun_nrise", rise_t.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("rerun_rise_t", (i < rise_t.size()) ? rise_t[i] : -1, exp_rr[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
